// File: rtl/piece_move_ctrl.sv
// Falling-piece move controller: queues player and gravity requests, asks one
// external legality checker per move, and owns the piece position.
module piece_move_ctrl #(
  parameter int SPAWN_X = 6,
  parameter int SPAWN_Y = 0,
  parameter int X_MAX   = 12,
  parameter int Y_MAX   = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       spawnReq,
  input  logic       leftReq,
  input  logic       rightReq,
  input  logic       dropTick,
  input  logic       canMoveLeft,
  input  logic       canMoveRight,
  input  logic       canMoveDown,
  output logic       enLeft,
  output logic       enRight,
  output logic       enDown,
  output logic [3:0] XPOS,
  output logic [4:0] YPOS,
  output logic       lockPiece,
  output logic       busy
);

  localparam logic [3:0] SPAWN_X_V = 4'(SPAWN_X);
  localparam logic [4:0] SPAWN_Y_V = 5'(SPAWN_Y);
  localparam logic [3:0] X_MAX_V   = 4'(X_MAX);
  localparam logic [4:0] Y_MAX_V   = 5'(Y_MAX);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_IDLE,
    S_ISSUE,
    S_EVAL,
    S_LOCKED
  } state_t;

  typedef enum logic [1:0] {
    OP_DOWN,
    OP_LEFT,
    OP_RIGHT
  } op_t;

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [3:0] xpos_q, xpos_d;
  logic [4:0] ypos_q, ypos_d;
  logic       pend_left_q, pend_left_d;
  logic       pend_right_q, pend_right_d;
  logic       pend_down_q, pend_down_d;
  logic       lock_q, lock_d;
  logic       accept_req;
  logic       clear_all;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pend_down_d  = pend_down_q;
    lock_d       = 1'b0;
    clear_all    = 1'b0;
    accept_req   = (state_q == S_IDLE) || (state_q == S_ISSUE) || (state_q == S_EVAL);

    case (state_q)
      S_IDLE: begin
        if (pend_down_q) begin
          op_d        = OP_DOWN;
          pend_down_d = 1'b0;
          state_d     = S_ISSUE;
        end else if (pend_left_q && pend_right_q) begin
          // Opposing moves cancel each other without consulting a checker.
          pend_left_d  = 1'b0;
          pend_right_d = 1'b0;
        end else if (pend_left_q) begin
          op_d        = OP_LEFT;
          pend_left_d = 1'b0;
          state_d     = S_ISSUE;
        end else if (pend_right_q) begin
          op_d         = OP_RIGHT;
          pend_right_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: state_d = S_EVAL;

      S_EVAL: begin
        state_d = S_IDLE;
        case (op_q)
          OP_LEFT: begin
            if (canMoveLeft && (xpos_q != 4'd0)) xpos_d = xpos_q - 4'd1;
          end
          OP_RIGHT: begin
            if (canMoveRight && (xpos_q < X_MAX_V)) xpos_d = xpos_q + 4'd1;
          end
          OP_DOWN: begin
            if (canMoveDown && (ypos_q < Y_MAX_V)) begin
              ypos_d = ypos_q + 5'd1;
            end else begin
              lock_d    = 1'b1;
              clear_all = 1'b1;
              state_d   = S_LOCKED;
            end
          end
          default: ;
        endcase
      end

      default: ;
    endcase

    // A request arriving on the cycle its older twin is serviced stays pending.
    if (accept_req) begin
      pend_left_d  = pend_left_d  | leftReq;
      pend_right_d = pend_right_d | rightReq;
      pend_down_d  = pend_down_d  | dropTick;
    end

    if (clear_all) begin
      pend_left_d  = 1'b0;
      pend_right_d = 1'b0;
      pend_down_d  = 1'b0;
    end

    // A spawn wins over everything in flight, including a lock on this edge.
    if (spawnReq) begin
      xpos_d       = SPAWN_X_V;
      ypos_d       = SPAWN_Y_V;
      pend_left_d  = 1'b0;
      pend_right_d = 1'b0;
      pend_down_d  = 1'b0;
      lock_d       = 1'b0;
      state_d      = S_IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (Reset) begin
      state_q      <= S_EMPTY;
      op_q         <= OP_DOWN;
      xpos_q       <= SPAWN_X_V;
      ypos_q       <= SPAWN_Y_V;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      pend_down_q  <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_down_q  <= pend_down_d;
      lock_q       <= lock_d;
    end
  end

  // Enables decode from registered state only, so they are one-hot and glitch-free.
  assign enLeft    = (state_q == S_ISSUE) && (op_q == OP_LEFT);
  assign enRight   = (state_q == S_ISSUE) && (op_q == OP_RIGHT);
  assign enDown    = (state_q == S_ISSUE) && (op_q == OP_DOWN);
  assign XPOS      = xpos_q;
  assign YPOS      = ypos_q;
  assign lockPiece = lock_q;
  // EMPTY and LOCKED hold no move in flight, so only ISSUE and EVAL report busy.
  assign busy      = (state_q == S_ISSUE) || (state_q == S_EVAL);

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Scoreboard bench for piece_move_ctrl: a move-level reference model queues
// timed events, a monitor compares what the DUT actually shows.
module tb_piece_move_ctrl;

  localparam int SX = 6;
  localparam int SY = 0;
  localparam int XM = 12;
  localparam int YM = 16;

  logic       Clock = 1'b0;
  logic       Reset, spawnReq, leftReq, rightReq, dropTick;
  logic       canMoveLeft, canMoveRight, canMoveDown;
  logic       enLeft, enRight, enDown, lockPiece, busy;
  logic [3:0] XPOS;
  logic [4:0] YPOS;

  piece_move_ctrl #(.SPAWN_X(SX), .SPAWN_Y(SY), .X_MAX(XM), .Y_MAX(YM)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .spawnReq    (spawnReq),
    .leftReq     (leftReq),
    .rightReq    (rightReq),
    .dropTick    (dropTick),
    .canMoveLeft (canMoveLeft),
    .canMoveRight(canMoveRight),
    .canMoveDown (canMoveDown),
    .enLeft      (enLeft),
    .enRight     (enRight),
    .enDown      (enDown),
    .XPOS        (XPOS),
    .YPOS        (YPOS),
    .lockPiece   (lockPiece),
    .busy        (busy)
  );

  always #5 Clock = ~Clock;

  typedef enum logic [7:0] {
    EV_EN_L = 8'd1,
    EV_EN_R = 8'd2,
    EV_EN_D = 8'd3,
    EV_POS  = 8'd4,
    EV_LOCK = 8'd5
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t    kind;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [31:0] cyc;
  } ev_t;

  ev_t exp_q[$];
  bit  grant_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  mon_en   = 1'b0;

  // Reference model: piece position and whether a live piece accepts moves.
  int  mx = SX;
  int  my = SY;
  bit  m_active = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input ev_kind_t k, input int x, input int y, input int c);
    ev_t e;
    e.kind = k;
    e.x    = 8'(x);
    e.y    = 8'(y);
    e.cyc  = 32'(c);
    return e;
  endfunction

  task automatic observe(input ev_t o);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 64'(o), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check("scoreboard_event", 64'(o), 64'(e));
    end
  endtask

  // Monitor: turns enables, position changes and lock pulses into events.
  logic [3:0] prev_x;
  logic [4:0] prev_y;
  always @(negedge Clock) begin
    if (mon_en) begin
      if (enLeft || enRight || enDown) begin
        check("enable_onehot", 64'($countones({enLeft, enRight, enDown})), 64'(1));
        check("busy_during_issue", 64'(busy), 64'(1));
        if (enLeft)       observe(mk(EV_EN_L, int'(XPOS), int'(YPOS), cyc));
        else if (enRight) observe(mk(EV_EN_R, int'(XPOS), int'(YPOS), cyc));
        else              observe(mk(EV_EN_D, int'(XPOS), int'(YPOS), cyc));
      end
      if ((XPOS != prev_x) || (YPOS != prev_y))
        observe(mk(EV_POS, int'(XPOS), int'(YPOS), cyc));
      if (lockPiece) observe(mk(EV_LOCK, int'(XPOS), int'(YPOS), cyc));
    end
    prev_x = XPOS;
    prev_y = YPOS;
  end

  // Checker responder: answers an enable one cycle later, then flips the answer.
  initial begin
    logic [2:0] which;
    bit         g;
    canMoveLeft  = 1'b0;
    canMoveRight = 1'b0;
    canMoveDown  = 1'b0;
    forever begin
      @(negedge Clock);
      if (enLeft || enRight || enDown) begin
        which = {enLeft, enRight, enDown};
        g = (grant_q.size() > 0) ? grant_q.pop_front() : 1'b1;
        @(posedge Clock); #1;
        if (which[2]) canMoveLeft  = g;
        if (which[1]) canMoveRight = g;
        if (which[0]) canMoveDown  = g;
        @(posedge Clock); #1;
        if (which[2]) canMoveLeft  = !g;
        if (which[1]) canMoveRight = !g;
        if (which[0]) canMoveDown  = !g;
      end
    end
  end

  // Requests pulsed together (or within two cycles) starting at edge p.
  // Service order drop > left > right; opposing left+right cancel; each move takes 3 cycles.
  task automatic model_batch(input int p, input bit d, input bit l, input bit r,
                             input bit gd, input bit gl, input bit gr, output int n);
    n = 0;
    if (!m_active) return;
    if (d) begin
      exp_q.push_back(mk(EV_EN_D, mx, my, p + 1));
      grant_q.push_back(gd);
      n = 1;
      if (gd && (my < YM)) begin
        my++;
        exp_q.push_back(mk(EV_POS, mx, my, p + 3));
      end else begin
        exp_q.push_back(mk(EV_LOCK, mx, my, p + 3));
        m_active = 1'b0;
        return;
      end
    end
    if (l && !r) begin
      exp_q.push_back(mk(EV_EN_L, mx, my, p + 3 * n + 1));
      grant_q.push_back(gl);
      if (gl && (mx > 0)) begin
        mx--;
        exp_q.push_back(mk(EV_POS, mx, my, p + 3 * n + 3));
      end
      n++;
    end else if (r && !l) begin
      exp_q.push_back(mk(EV_EN_R, mx, my, p + 3 * n + 1));
      grant_q.push_back(gr);
      if (gr && (mx < XM)) begin
        mx++;
        exp_q.push_back(mk(EV_POS, mx, my, p + 3 * n + 3));
      end
      n++;
    end
  endtask

  task automatic model_respawn(input int p, input bit live);
    if ((mx != SX) || (my != SY)) exp_q.push_back(mk(EV_POS, SX, SY, p));
    mx = SX;
    my = SY;
    m_active = live;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_batch(input bit d, input bit l, input bit r,
                          input bit gd, input bit gl, input bit gr);
    int p, n;
    p = cyc + 1;
    dropTick = d;
    leftReq  = l;
    rightReq = r;
    model_batch(p, d, l, r, gd, gl, gr, n);
    tick();
    dropTick = 1'b0;
    leftReq  = 1'b0;
    rightReq = 1'b0;
    repeat (3 * n + 2) tick();
  endtask

  task automatic do_spawn();
    spawnReq = 1'b1;
    model_respawn(cyc + 1, 1'b1);
    tick();
    spawnReq = 1'b0;
    tick();
  endtask

  // Spawn lands on the EVAL edge of a left (is_drop=0) or drop (is_drop=1).
  task automatic do_spawn_abort(input bit is_drop, input bit g);
    int p;
    p = cyc + 1;
    exp_q.push_back(mk(is_drop ? EV_EN_D : EV_EN_L, mx, my, p + 1));
    grant_q.push_back(g);
    dropTick = is_drop;
    leftReq  = !is_drop;
    tick();
    dropTick = 1'b0;
    leftReq  = 1'b0;
    tick();
    tick();
    spawnReq = 1'b1;
    model_respawn(p + 3, 1'b1);
    tick();
    spawnReq = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, n;
    Reset    = 1'b1;
    spawnReq = 1'b0;
    leftReq  = 1'b0;
    rightReq = 1'b0;
    dropTick = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    check("reset_xpos", 64'(XPOS), 64'(SX));
    check("reset_ypos", 64'(YPOS), 64'(SY));
    check("reset_enables", 64'({enLeft, enRight, enDown}), 64'(0));
    check("reset_lock", 64'(lockPiece), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    mon_en = 1'b1;

    // No piece yet: a move request must be dropped.
    do_batch(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Spawn, one granted left: 6 -> 5 three cycles after the pulse.
    do_spawn();
    do_batch(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("first_left_xpos", 64'(XPOS), 64'(mx));

    // Walk into the left wall; the last granted left must not wrap.
    repeat (6) do_batch(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("left_wall_xpos", 64'(XPOS), 64'(0));

    repeat (3) do_batch(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    do_batch(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("left_right_cancel_xpos", 64'(XPOS), 64'(3));

    // Walk into the right wall.
    repeat (11) do_batch(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("right_wall_xpos", 64'(XPOS), 64'(XM));

    // Drop and right together: down first, then right, six cycles in all.
    repeat (2) do_batch(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    do_batch(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // A left arriving while the drop is still in ISSUE waits its turn.
    p = cyc + 1;
    model_batch(p, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, n);
    dropTick = 1'b1;
    tick();
    dropTick = 1'b0;
    tick();
    leftReq = 1'b1;
    tick();
    leftReq = 1'b0;
    repeat (6) tick();

    // Spawn on the EVAL edge beats a granted left and a refused drop.
    do_spawn_abort(1'b0, 1'b1);
    repeat (2) do_batch(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    do_spawn_abort(1'b1, 1'b0);

    // Refused drop locks; moves are ignored until the next spawn.
    do_batch(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    do_batch(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("locked_ypos", 64'(YPOS), 64'(my));
    do_batch(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    do_spawn();
    check("respawn_xpos", 64'(XPOS), 64'(SX));
    check("respawn_ypos", 64'(YPOS), 64'(SY));
    do_batch(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Floor: 16 granted drops reach Y_MAX, the 17th is refused by the bound.
    do_spawn();
    repeat (17) do_batch(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("floor_ypos", 64'(YPOS), 64'(YM));

    // Reset during the ISSUE cycle of a refused drop: no lock, back to empty.
    do_spawn();
    repeat (2) do_batch(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    p = cyc + 1;
    exp_q.push_back(mk(EV_EN_D, mx, my, p + 1));
    grant_q.push_back(1'b0);
    dropTick = 1'b1;
    tick();
    dropTick = 1'b0;
    tick();
    Reset = 1'b1;
    model_respawn(p + 2, 1'b0);
    tick();
    Reset = 1'b0;
    repeat (4) tick();
    check("reset_mid_ypos", 64'(YPOS), 64'(SY));
    check("reset_mid_lock", 64'(lockPiece), 64'(0));
    do_batch(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Randomized play.
    do_spawn();
    for (int i = 0; i < 250; i++) begin
      if (!m_active || ($urandom_range(0, 99) < 5)) begin
        do_spawn();
      end else begin
        do_batch(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0));
      end
    end

    repeat (10) tick();
    check("final_xpos", 64'(XPOS), 64'(mx));
    check("final_ypos", 64'(YPOS), 64'(my));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
